// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and constants for the two-port register access arbiter.
package reg_access_arbiter_pkg;

   // Transaction sequencer states; the encoding is fixed so it can be probed.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      ACK    = 2'd3
   } arb_state_t;

   // Port indices as seen on the owner output.
   localparam logic PORT_I2C    = 1'b0;
   localparam logic PORT_SENSOR = 1'b1;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side handshake bundle for both arbiter ports.
// master: the requesters (I2C slave, sensor sampler); slave: the arbiter.
interface reg_access_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, rdata0, rdata1
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, rdata0, rdata1
   );
endinterface

// File: rtl/reg_arb_rr2.sv
// Two-requester picker, purely combinational.
// Build option: REG_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module reg_arb_rr2
   import reg_access_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_winner
);

`ifdef REG_ARB_FIXED_PRIO_EN
   // Fixed priority ignores grant history; port 1 may starve.
   logic w_unused_last;
   assign w_unused_last = i_last_grant;

   // Port 1 only wins when port 0 is silent.
   always_comb begin
      o_winner = PORT_I2C;
      if (i_req1 && !i_req0) o_winner = PORT_SENSOR;
   end
`else
   // Round-robin: a lone requester wins, a tie goes to the port not granted last.
   always_comb begin
      o_winner = PORT_I2C;
      if (i_req0 && i_req1) o_winner = ~i_last_grant;
      else if (i_req1)      o_winner = PORT_SENSOR;
   end
`endif

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbiter/sequencer sharing one register-file port between the I2C slave
// (port 0) and the sensor sampler (port 1). One full transaction at a time:
// IDLE -> ACCESS (strobe) -> RESP (capture read data) -> ACK (pulse).
// Build option: REG_ARB_FIXED_PRIO_EN (handled inside reg_arb_rr2).
module reg_access_arbiter
   import reg_access_arbiter_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
)(
   input  logic                i_clk,
   input  logic                i_rst,
   reg_access_arbiter_if.slave io_req,
   output logic [ADDR_W-1:0]   o_reg_addr,
   output logic [DATA_W-1:0]   o_reg_wdata,
   output logic                o_reg_we,
   input  logic [DATA_W-1:0]   i_reg_rdata,
   output logic                o_busy,
   output logic                o_owner
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              w_any_req;
   logic              w_winner;
   logic              w_grant;
   logic              r_owner;
   logic              r_last_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   assign w_any_req = io_req.req0 | io_req.req1;
   assign w_grant   = (r_state == IDLE) && w_any_req;

   reg_arb_rr2 u_rr2 (
      .i_req0       (io_req.req0),
      .i_req1       (io_req.req1),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: a granted transaction always runs the full fixed sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = ACK;
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture the winner's request fields at grant so later changes on the
   // requester side cannot disturb the transaction in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner      <= PORT_I2C;
         r_last_grant <= PORT_SENSOR;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else if (w_grant) begin
         r_owner      <= w_winner;
         r_last_grant <= w_winner;
         if (w_winner == PORT_SENSOR) begin
            r_we    <= io_req.we1;
            r_addr  <= io_req.addr1;
            r_wdata <= io_req.wdata1;
         end else begin
            r_we    <= io_req.we0;
            r_addr  <= io_req.addr0;
            r_wdata <= io_req.wdata0;
         end
      end
   end

   // Read data returns one cycle after the address, i.e. during RESP; only
   // the owner's register is loaded, and writes leave both untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (r_state == RESP && !r_we) begin
         if (r_owner == PORT_SENSOR) r_rdata1 <= i_reg_rdata;
         else                        r_rdata0 <= i_reg_rdata;
      end
   end

   // Write strobe is masked by reset so an aborted ACCESS never writes.
   assign o_reg_we    = (r_state == ACCESS) && r_we && !i_rst;
   assign o_reg_addr  = r_addr;
   assign o_reg_wdata = r_wdata;
   assign o_busy      = (r_state != IDLE);
   assign o_owner     = r_owner;

   assign io_req.ack0   = (r_state == ACK) && (r_owner == PORT_I2C);
   assign io_req.ack1   = (r_state == ACK) && (r_owner == PORT_SENSOR);
   assign io_req.rdata0 = r_rdata0;
   assign io_req.rdata1 = r_rdata1;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: a simple register-file stub plus a
// transaction-level schedule model that predicts grant order, ack cycles,
// write strobes and returned read data.
module tb_reg_access_arbiter;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int MAXN   = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata = '0;
   logic              reg_we;
   logic              busy;
   logic              owner;

   reg_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .io_req      (bus),
      .o_reg_addr  (reg_addr),
      .o_reg_wdata (reg_wdata),
      .o_reg_we    (reg_we),
      .i_reg_rdata (reg_rdata),
      .o_busy      (busy),
      .o_owner     (owner)
   );

   // Register-file stub: 16 registers, anything above reads 0 and ignores writes.
   logic [DATA_W-1:0] rf [16] = '{default: '0};
   always @(posedge clk) begin
      if (reg_we && reg_addr < 16) rf[reg_addr[3:0]] <= reg_wdata;
      reg_rdata <= (reg_addr < 16) ? rf[reg_addr[3:0]] : '0;
   end

   // Reference model state.
   logic [DATA_W-1:0] m_mem [16];
   logic [DATA_W-1:0] m_rd  [2];
   bit                m_last;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic model_reset();
      m_last  = 1'b1;
      m_rd[0] = '0;
      m_rd[1] = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Run one scenario starting at a negedge with the arbiter idle. Each port
   // raises req at negedge d, wants c transactions with fixed fields, and drops
   // req in its final ack cycle.
   task automatic run_txn(input int d0, input int c0, input bit we0, input logic [7:0] a0, input logic [7:0] w0,
                          input int d1, input int c1, input bit we1, input logic [7:0] a1, input logic [7:0] w1,
                          input string tag);
      bit          e_ack0 [MAXN];
      bit          e_ack1 [MAXN];
      bit          e_we   [MAXN];
      bit          e_busy [MAXN];
      bit          e_rdv  [MAXN];
      bit          e_rdp  [MAXN];
      logic [7:0]  e_wa   [MAXN];
      logic [7:0]  e_wd   [MAXN];
      logic [7:0]  e_rdval[MAXN];
      int          rem [2];
      int          dl  [2];
      int          seen[2];
      int          e, last_ack;
      bit          c_0, c_1, w, t_we;
      logic [7:0]  t_a, t_d;
      for (int i = 0; i < MAXN; i++) begin
         e_ack0[i] = 0; e_ack1[i] = 0; e_we[i] = 0; e_busy[i] = 0;
         e_rdv[i] = 0; e_rdp[i] = 0; e_wa[i] = '0; e_wd[i] = '0; e_rdval[i] = '0;
      end
      rem[0] = c0; rem[1] = c1; dl[0] = d0; dl[1] = d1; seen[0] = 0; seen[1] = 0;
      // Schedule: arbitration edge e; ACCESS seen at negedge e, ack at e+2,
      // next arbitration at e+4. A req raised at negedge d is visible at edge d+1.
      e = 1; last_ack = 0;
      while ((rem[0] > 0 || rem[1] > 0) && e < MAXN - 4) begin
         c_0 = rem[0] > 0 && dl[0] + 1 <= e;
         c_1 = rem[1] > 0 && dl[1] + 1 <= e;
         if (!c_0 && !c_1) begin e++; continue; end
`ifdef REG_ARB_FIXED_PRIO_EN
         w = (c_0 && c_1) ? 1'b0 : c_1;
`else
         w = (c_0 && c_1) ? ~m_last : c_1;
`endif
         m_last = w;
         t_we = w ? we1 : we0;
         t_a  = w ? a1 : a0;
         t_d  = w ? w1 : w0;
         for (int k = e; k <= e + 2; k++) e_busy[k] = 1;
         if (t_we) begin
            e_we[e] = 1; e_wa[e] = t_a; e_wd[e] = t_d;
            if (t_a < 16) m_mem[t_a[3:0]] = t_d;
         end else begin
            e_rdv[e+2] = 1; e_rdp[e+2] = w;
            e_rdval[e+2] = (t_a < 16) ? m_mem[t_a[3:0]] : 8'h00;
         end
         if (w) e_ack1[e+2] = 1; else e_ack0[e+2] = 1;
         rem[w]--;
         last_ack = e + 2;
         e += 4;
      end
      bus.we0 = we0; bus.addr0 = a0; bus.wdata0 = w0;
      bus.we1 = we1; bus.addr1 = a1; bus.wdata1 = w1;
      if (d0 == 0 && c0 > 0) bus.req0 = 1'b1;
      if (d1 == 0 && c1 > 0) bus.req1 = 1'b1;
      for (int n = 1; n <= last_ack + 1; n++) begin
         @(negedge clk);
         if (e_rdv[n]) m_rd[e_rdp[n]] = e_rdval[n];
         n_checks++;
         if (bus.ack0 !== e_ack0[n]) begin n_fail++; $display("FAIL %s ack0 @%0d: got %b want %b", tag, n, bus.ack0, e_ack0[n]); end
         n_checks++;
         if (bus.ack1 !== e_ack1[n]) begin n_fail++; $display("FAIL %s ack1 @%0d: got %b want %b", tag, n, bus.ack1, e_ack1[n]); end
         n_checks++;
         if (reg_we !== e_we[n]) begin n_fail++; $display("FAIL %s reg_we @%0d: got %b want %b", tag, n, reg_we, e_we[n]); end
         if (e_we[n]) begin
            n_checks++;
            if (reg_addr !== e_wa[n] || reg_wdata !== e_wd[n]) begin
               n_fail++; $display("FAIL %s reg_addr/wdata @%0d: got %h/%h want %h/%h", tag, n, reg_addr, reg_wdata, e_wa[n], e_wd[n]);
            end
         end
         n_checks++;
         if (busy !== e_busy[n]) begin n_fail++; $display("FAIL %s busy @%0d: got %b want %b", tag, n, busy, e_busy[n]); end
         if (e_ack0[n] || e_ack1[n]) begin
            n_checks++;
            if (owner !== e_ack1[n]) begin n_fail++; $display("FAIL %s owner @%0d: got %b want %b", tag, n, owner, e_ack1[n]); end
         end
         n_checks++;
         if (bus.rdata0 !== m_rd[0]) begin n_fail++; $display("FAIL %s rdata0 @%0d: got %h want %h", tag, n, bus.rdata0, m_rd[0]); end
         n_checks++;
         if (bus.rdata1 !== m_rd[1]) begin n_fail++; $display("FAIL %s rdata1 @%0d: got %h want %h", tag, n, bus.rdata1, m_rd[1]); end
         // Requester behaviour: drop req in the final ack cycle, raise on schedule.
         if (bus.ack0) begin seen[0]++; if (seen[0] >= c0) bus.req0 = 1'b0; end
         if (bus.ack1) begin seen[1]++; if (seen[1] >= c1) bus.req1 = 1'b0; end
         if (n == d0 && c0 > 0 && seen[0] < c0) bus.req0 = 1'b1;
         if (n == d1 && c1 > 0 && seen[1] < c1) bus.req1 = 1'b1;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.ack0, bus.ack1, reg_we, busy, owner} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got ack0/ack1/we/busy/owner=%b want 00000", {bus.ack0, bus.ack1, reg_we, busy, owner});
      end
      n_checks++;
      if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_bus: got addr/wdata=%h/%h want 00/00", reg_addr, reg_wdata);
      end
      n_checks++;
      if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
         n_fail++; $display("FAIL reset_rdata: got %h/%h want 00/00", bus.rdata0, bus.rdata1);
      end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy: got %b want 0", busy); end
   endtask

   task automatic test_single_write();
      run_txn(0, 1, 1'b1, 8'h02, 8'hA5, 0, 0, 1'b0, 8'h00, 8'h00, "single_write");
   endtask

   task automatic test_single_read();
      run_txn(0, 0, 1'b0, 8'h00, 8'h00, 0, 1, 1'b0, 8'h02, 8'h00, "single_read");
   endtask

   task automatic test_tie();
      apply_reset();
      run_txn(0, 1, 1'b1, 8'h00, 8'h11, 0, 1, 1'b1, 8'h01, 8'h22, "tie1");
      run_txn(0, 1, 1'b0, 8'h01, 8'h00, 0, 1, 1'b0, 8'h00, 8'h00, "tie2");
   endtask

   task automatic test_held();
      run_txn(0, 2, 1'b1, 8'h05, 8'h5A, 0, 0, 1'b0, 8'h00, 8'h00, "held_solo");
      run_txn(0, 2, 1'b1, 8'h06, 8'h66, 1, 1, 1'b0, 8'h05, 8'h00, "held_contend");
   endtask

   task automatic test_reset_mid();
      run_txn(0, 1, 1'b1, 8'h03, 8'h3C, 0, 0, 1'b0, 8'h00, 8'h00, "rstmid_preload");
      bus.we0 = 1'b1; bus.addr0 = 8'h03; bus.wdata0 = 8'hFF; bus.req0 = 1'b1;
      @(negedge clk);
      n_checks++;
      if (reg_we !== 1'b1) begin n_fail++; $display("FAIL rstmid access_we: got %b want 1", reg_we); end
      rst = 1'b1;
      bus.req0 = 1'b0;
      #1;
      n_checks++;
      if (reg_we !== 1'b0) begin n_fail++; $display("FAIL rstmid gated_we: got %b want 0", reg_we); end
      @(negedge clk);
      n_checks++;
      if ({busy, bus.ack0, bus.ack1, reg_we} !== 4'b0) begin
         n_fail++; $display("FAIL rstmid idle: got busy/ack0/ack1/we=%b want 0000", {busy, bus.ack0, bus.ack1, reg_we});
      end
      rst = 1'b0;
      model_reset();
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (bus.ack0 !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid no_ack: got ack0/busy=%b%b want 00", bus.ack0, busy);
         end
      end
      run_txn(0, 1, 1'b0, 8'h03, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00, "rstmid_readback");
   endtask

   task automatic test_out_of_range();
      run_txn(0, 1, 1'b0, 8'h02, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00, "oor_prime");
      run_txn(0, 1, 1'b0, 8'h80, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00, "oor_read");
   endtask

   function automatic logic [7:0] rand_addr();
      int v;
      v = $urandom_range(0, 19);
      return (v < 16) ? 8'(v) : 8'(8'h80 + v);
   endfunction

   task automatic test_random();
      int d0, c0, d1, c1;
      for (int r = 0; r < 40; r++) begin
         d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3);
         c0 = $urandom_range(0, 2); c1 = $urandom_range(0, 2);
         if (c0 == 0 && c1 == 0) c0 = 1;
         run_txn(d0, c0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom),
                 d1, c1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), "random");
      end
   endtask

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = '0; bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      model_reset();
      test_reset();
      test_single_write();
      test_single_read();
      test_tie();
      test_held();
      test_reset_mid();
      test_out_of_range();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
